// File: rtl/reg_demux4_pkg.sv
// Shared definitions for the registered 1-to-4 demultiplexer: slot index
// constants, default widths and the slot-advance helper.
package reg_demux4_pkg;

  localparam int DEFAULT_INPUT_BIT_WIDTH = 8;
  localparam int DEFAULT_BUS_WIDTH       = 2;
  localparam int NUM_SLOTS               = 4;

  localparam int SLOT_A = 0;
  localparam int SLOT_B = 1;
  localparam int SLOT_C = 2;
  localparam int SLOT_D = 3;

  // Next slot in A,B,C,D order; D wraps back to A.
  function automatic logic [DEFAULT_BUS_WIDTH-1:0] nextSlot(
    input logic [DEFAULT_BUS_WIDTH-1:0] slot
  );
    return slot + DEFAULT_BUS_WIDTH'(1);
  endfunction

endpackage

// File: rtl/reg_demux4_slot.sv
// One-entry holding register with a valid flag. Load writes a new word and
// sets Valid; Drain (consumer ready) clears Valid unless a load lands in the
// same cycle. Data keeps its last value after a drain.
module reg_demux4_slot #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic             Drain,
  input  logic [WIDTH-1:0] LoadData,
  output logic [WIDTH-1:0] Data,
  output logic             Valid
);

  // Slot state: load has priority over drain so fill+drain keeps Valid high.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (Reset) begin
      // NOTE: the data word is reset too; consumers see 0, not stale words, after reset.
      Data  <= '0;
      Valid <= 1'b0;
    end else if (Load) begin
      Data  <= LoadData;
      Valid <= 1'b1;
    end else if (Drain) begin
      Valid <= 1'b0;
    end
  end

endmodule

// File: rtl/reg_demux4.sv
// Registered 1-to-4 demultiplexer with per-slot valid/ready handshakes.
// Optional feature: define REG_DEMUX4_ROUND_ROBIN_EN to ignore Select and
// route words A,B,C,D,A,... with an internal pointer that advances on accept.
// InputReady is combinational from Select (or the pointer), slot valid and
// the selected consumer's ready; all outputs to consumers are registered.
module reg_demux4
  import reg_demux4_pkg::*;
#(
  parameter int INPUT_BIT_WIDTH = DEFAULT_INPUT_BIT_WIDTH,
  parameter int BUS_WIDTH       = DEFAULT_BUS_WIDTH
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [INPUT_BIT_WIDTH-1:0] Input,
  input  logic                       InputValid,
  output logic                       InputReady,
  input  logic [BUS_WIDTH-1:0]       Select,
  output logic [INPUT_BIT_WIDTH-1:0] OutputA,
  output logic [INPUT_BIT_WIDTH-1:0] OutputB,
  output logic [INPUT_BIT_WIDTH-1:0] OutputC,
  output logic [INPUT_BIT_WIDTH-1:0] OutputD,
  output logic                       OutputValidA,
  output logic                       OutputValidB,
  output logic                       OutputValidC,
  output logic                       OutputValidD,
  input  logic                       OutputReadyA,
  input  logic                       OutputReadyB,
  input  logic                       OutputReadyC,
  input  logic                       OutputReadyD
);

  logic [BUS_WIDTH-1:0]       activeSlot;
  logic [NUM_SLOTS-1:0]       slotValid;
  logic [NUM_SLOTS-1:0]       slotReady;
  logic [NUM_SLOTS-1:0]       slotLoad;
  logic [INPUT_BIT_WIDTH-1:0] slotData [NUM_SLOTS];
  logic                       accept;

  assign slotReady = {OutputReadyD, OutputReadyC, OutputReadyB, OutputReadyA};

`ifdef REG_DEMUX4_ROUND_ROBIN_EN
  logic [BUS_WIDTH-1:0] rrPointer;
  logic                 unusedSelect;

  // Round-robin pointer: moves only on an accepted word, so a blocked slot stalls the stream.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rrPointer <= '0;
    end else if (accept) begin
      rrPointer <= nextSlot(rrPointer);
    end
  end

  assign activeSlot   = rrPointer;
  assign unusedSelect = ^Select;
`else
  assign activeSlot = Select;
`endif

  // A full slot still accepts when its consumer drains it in the same cycle.
  assign InputReady = !slotValid[activeSlot] | slotReady[activeSlot];
  assign accept     = InputValid & InputReady;

  // Load decode: at most one slot loads, and only on an accepted word.
  always_comb begin
    // NOTE: default assigned first so no path leaves slotLoad unassigned (no latch).
    slotLoad = '0;
    if (accept) begin
      slotLoad[activeSlot] = 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : gSlot
    reg_demux4_slot #(
      .WIDTH(INPUT_BIT_WIDTH)
    ) uSlot (
      .Clk     (Clk),
      .Reset   (Reset),
      .Load    (slotLoad[i]),
      .Drain   (slotReady[i]),
      .LoadData(Input),
      .Data    (slotData[i]),
      .Valid   (slotValid[i])
    );
  end

  assign OutputA      = slotData[SLOT_A];
  assign OutputB      = slotData[SLOT_B];
  assign OutputC      = slotData[SLOT_C];
  assign OutputD      = slotData[SLOT_D];
  assign OutputValidA = slotValid[SLOT_A];
  assign OutputValidB = slotValid[SLOT_B];
  assign OutputValidC = slotValid[SLOT_C];
  assign OutputValidD = slotValid[SLOT_D];

endmodule

// File: tb/tb_reg_demux4.sv
// Self-checking bench for reg_demux4. A per-slot expected-word queue is fed
// when the producer side sees a word accepted; a negedge monitor checks
// slot valids and data against those queues and pops on each delivery.
// Builds for either setting of REG_DEMUX4_ROUND_ROBIN_EN.
module tb_reg_demux4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] Input = '0;
  logic       InputValid = 1'b0;
  logic       InputReady;
  logic [1:0] Select = '0;
  logic [7:0] OutputA, OutputB, OutputC, OutputD;
  logic       OutputValidA, OutputValidB, OutputValidC, OutputValidD;
  logic [3:0] rdy = 4'hF;

  int errors = 0;
  int checks = 0;
  bit monEn  = 1'b0;

  // Reference model: what each slot should hold, in arrival order.
  logic [7:0] sbQ [4][$];
  logic [7:0] lastWord [4];
  int         rrPtr = 0;

  reg_demux4 dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Input       (Input),
    .InputValid  (InputValid),
    .InputReady  (InputReady),
    .Select      (Select),
    .OutputA     (OutputA),
    .OutputB     (OutputB),
    .OutputC     (OutputC),
    .OutputD     (OutputD),
    .OutputValidA(OutputValidA),
    .OutputValidB(OutputValidB),
    .OutputValidC(OutputValidC),
    .OutputValidD(OutputValidD),
    .OutputReadyA(rdy[0]),
    .OutputReadyB(rdy[1]),
    .OutputReadyC(rdy[2]),
    .OutputReadyD(rdy[3])
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] outData(input int s);
    case (s)
      0: return OutputA;
      1: return OutputB;
      2: return OutputC;
      default: return OutputD;
    endcase
  endfunction

  function automatic logic outValid(input int s);
    case (s)
      0: return OutputValidA;
      1: return OutputValidB;
      2: return OutputValidC;
      default: return OutputValidD;
    endcase
  endfunction

  function automatic int targetSlot(input int requested);
`ifdef REG_DEMUX4_ROUND_ROBIN_EN
    return rrPtr;
`else
    return requested;
`endif
  endfunction

  // Monitor: slot state must match the model; a valid&ready slot delivers its head word.
  always @(negedge Clk) begin
    if (monEn) begin
      for (int s = 0; s < 4; s++) begin
        check($sformatf("valid[%0d]", s), 32'(outValid(s)), 32'(sbQ[s].size() != 0));
        check($sformatf("data[%0d]", s), 32'(outData(s)), 32'(lastWord[s]));
        if (outValid(s) && rdy[s] && sbQ[s].size() != 0) begin
          logic [7:0] expWord;
          expWord = sbQ[s].pop_front();
          check($sformatf("deliver[%0d]", s), 32'(outData(s)), 32'(expWord));
        end
      end
    end
  end

  // One offer cycle: drive the word, compare InputReady with the model at negedge.
  task automatic offer(input int slot, input logic [7:0] data, output bit accepted);
    int tgt;
    bit expReady;
    Select     = 2'(slot);
    Input      = data;
    InputValid = 1'b1;
    @(negedge Clk);
    tgt      = targetSlot(slot);
    expReady = (sbQ[tgt].size() == 0) || (rdy[tgt] == 1'b1);
    check("InputReady", 32'(InputReady), 32'(expReady));
    accepted = expReady;
    if (expReady) begin
      #1;
      sbQ[tgt].push_back(data);
      lastWord[tgt] = data;
      rrPtr = (rrPtr + 1) % 4;
    end
    @(posedge Clk);
    #1;
    InputValid = 1'b0;
  endtask

  // Hold the word until accepted, optionally shuffling consumer readies each try.
  task automatic sendWord(input int slot, input logic [7:0] data, input bit randRdy);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 64 && !acc; t++) begin
      if (randRdy) rdy = 4'($urandom_range(0, 15) | $urandom_range(0, 15));
      offer(slot, data, acc);
    end
    if (!acc) check("sendTimeout", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Synchronous reset for one edge; the model drops everything at that edge.
  task automatic doReset();
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sbQ[s].delete();
      lastWord[s] = '0;
    end
    rrPtr = 0;
  endtask

  initial begin
    bit acc;
    for (int s = 0; s < 4; s++) lastWord[s] = '0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    monEn = 1'b1;

    // Reset state.
    check("rstValid", 32'({OutputValidD, OutputValidC, OutputValidB, OutputValidA}), 32'h0);
    check("rstData", {OutputD, OutputC, OutputB, OutputA}, 32'h0);

`ifndef REG_DEMUX4_ROUND_ROBIN_EN
    // Fan out 42,15,2,0 to A..D with readies high; each visible right after its edge.
    rdy = 4'hF;
    sendWord(0, 8'd42, 1'b0);
    check("latA", 32'({OutputValidA, OutputA}), 32'h12A);
    sendWord(1, 8'd15, 1'b0);
    check("latB", 32'({OutputValidB, OutputB}), 32'h10F);
    check("oneCycleA", 32'(OutputValidA), 32'h0);
    sendWord(2, 8'd2, 1'b0);
    check("latC", 32'({OutputValidC, OutputC}), 32'h102);
    sendWord(3, 8'd0, 1'b0);
    check("latD", 32'({OutputValidD, OutputD}), 32'h100);
    idle(2);

    // Blocked B: second word stalls until ReadyB rises, then 99 follows 15.
    rdy = 4'b1101;
    sendWord(1, 8'd15, 1'b0);
    offer(1, 8'd99, acc);
    check("stallB", 32'(acc), 32'd0);
    offer(1, 8'd99, acc);
    check("stallB2", 32'(acc), 32'd0);
    rdy = 4'hF;
    offer(1, 8'd99, acc);
    check("releaseB", 32'(acc), 32'd1);
    check("outB99", 32'({OutputValidB, OutputB}), 32'h163);
    idle(2);

    // C full and draining while 7 arrives: no bubble.
    rdy = 4'b1011;
    sendWord(2, 8'd5, 1'b0);
    rdy = 4'hF;
    offer(2, 8'd7, acc);
    check("fillDrainAcc", 32'(acc), 32'd1);
    check("fillDrainC", 32'({OutputValidC, OutputC}), 32'h107);
    idle(2);

    // B blocked full does not block D.
    rdy = 4'b1101;
    sendWord(1, 8'd11, 1'b0);
    offer(3, 8'd33, acc);
    check("dPastB", 32'(acc), 32'd1);
    check("outD33", 32'({OutputValidD, OutputD}), 32'h121);
    check("bHeld", 32'({OutputValidB, OutputB}), 32'h10B);
    rdy = 4'hF;
    idle(2);
`else
    // Round robin: Select pinned to 3, words land A,B,C,D,A.
    rdy = 4'hF;
    for (int i = 1; i <= 5; i++) begin
      sendWord(3, 8'(i), 1'b0);
      check($sformatf("rrSlot%0d", i), 32'({outValid((i - 1) % 4), outData((i - 1) % 4)}),
            32'h100 | 32'(i));
    end
    idle(2);
    // A blocked B stalls the stream rather than being skipped.
    doReset();
    rdy = 4'b1101;
    for (int i = 1; i <= 5; i++) sendWord(3, 8'(i), 1'b0);
    offer(3, 8'd6, acc);
    check("rrStallB", 32'(acc), 32'd0);
    rdy = 4'hF;
    offer(3, 8'd6, acc);
    check("rrReleaseB", 32'({acc, OutputValidB, OutputB}), 32'h306);
    idle(2);
`endif

    // Reset with every slot full: nothing stale survives.
    rdy = 4'h0;
    for (int s = 0; s < 4; s++) sendWord(s, 8'(8'hA0 + s), 1'b0);
    check("allFull", 32'({OutputValidD, OutputValidC, OutputValidB, OutputValidA}), 32'hF);
    doReset();
    check("rstFullValid", 32'({OutputValidD, OutputValidC, OutputValidB, OutputValidA}), 32'h0);
    check("rstFullData", {OutputD, OutputC, OutputB, OutputA}, 32'h0);
    rdy = 4'hF;
    idle(3);

    // Randomized traffic with shuffled consumer readies.
    for (int n = 0; n < 400; n++) begin
      sendWord($urandom_range(0, 3), 8'($urandom), 1'b1);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rdy = 4'hF;
    idle(3);
    for (int s = 0; s < 4; s++) check($sformatf("drained[%0d]", s), 32'(sbQ[s].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
